cim_adder_tree_acc: RTL and testbench

Parametrised bit-serial shift-accumulate adder tree for the CIM macro readout path. Each cycle it accepts one input bit-plane of NUM_IN unsigned column partial sums and reduces them through a registered adder tree. It then folds the plane sum into a signed accumulator, MSB plane first. It replaces the fixed 32x4b/4-plane adder with:
- a configurable plane count
- optional two's-complement weighting of the MSB plane
- a valid/ready handshake that tolerates gaps
- an explicit start/done protocol

---
 rtl/cim_adder_tree_acc.sv | 165 ++++++++++++++++
 tb/tb_cim_adder_tree_acc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cim_adder_tree_acc.sv
// Bit-serial shift-accumulate adder tree for the CIM macro readout path.
// Each accepted bit-plane is reduced to a plane sum, then folded MSB-first into a signed result.
module cim_adder_tree_acc #(
    parameter int NUM_IN   = 32,
    parameter int IN_W     = 4,
    parameter int MAX_BITS = 8,
    parameter int BITS_W   = 4,
    parameter int SUM_W    = IN_W + $clog2(NUM_IN) + 1,
    parameter int OUT_W    = SUM_W + MAX_BITS + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BITS_W-1:0]      cfg_bits,
    input  logic                   cfg_signed,
    input  logic                   in_valid,
    input  logic [NUM_IN*IN_W-1:0] in_data,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   out_valid,
    output logic [OUT_W-1:0]       out_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Zero planes behave as one; oversized requests saturate at MAX_BITS.
    function automatic logic [BITS_W-1:0] sat_bits(input logic [BITS_W-1:0] bits);
        logic [BITS_W-1:0] r;
        if (bits == '0)
            r = BITS_W'(1);
        else if (bits > BITS_W'(MAX_BITS))
            r = BITS_W'(MAX_BITS);
        else
            r = bits;
        return r;
    endfunction

    function automatic logic [SUM_W-1:0] plane_sum(input logic [NUM_IN*IN_W-1:0] data);
        logic [SUM_W-1:0] node [NUM_IN];
        for (int k = 0; k < NUM_IN; k++)
            node[k] = SUM_W'(data[k*IN_W +: IN_W]);
        for (int w = NUM_IN / 2; w >= 1; w = w / 2)
            for (int k = 0; k < w; k++)
                node[k] = node[2*k] + node[2*k+1];
        return node[0];
    endfunction

    // Horner step; the first plane of a signed operation carries negative weight.
    function automatic logic signed [OUT_W-1:0] horner(
        input logic signed [OUT_W-1:0] acc,
        input logic [SUM_W-1:0]        s,
        input logic                    first,
        input logic                    neg
    );
        logic signed [OUT_W-1:0] s_ext;
        logic signed [OUT_W-1:0] r;
        s_ext = $signed({{(OUT_W-SUM_W){1'b0}}, s});
        if (first)
            r = neg ? -s_ext : s_ext;
        else
            r = (acc <<< 1) + s_ext;
        return r;
    endfunction

    logic [1:0]              state_q, state_d;
    logic [BITS_W-1:0]       cnt_q, cnt_d;
    logic                    signed_q, signed_d;
    logic                    first_q, first_d;
    logic                    vld_p1_q, vld_p1_d;
    logic                    first_p1_q, first_p1_d;
    logic                    last_p1_q, last_p1_d;
    logic [SUM_W-1:0]        sum_p1_q, sum_p1_d;
    logic signed [OUT_W-1:0] acc_p2_q, acc_p2_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    accept;

    assign accept = in_valid && (state_q == ST_RUN);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        signed_d    = signed_q;
        first_d     = first_q;
        vld_p1_d    = accept;
        first_p1_d  = first_q;
        last_p1_d   = (cnt_q == BITS_W'(1));
        sum_p1_d    = accept ? plane_sum(in_data) : sum_p1_q;
        acc_p2_d    = acc_p2_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    cnt_d    = sat_bits(cfg_bits);
                    signed_d = cfg_signed;
                    first_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    cnt_d   = cnt_q - BITS_W'(1);
                    first_d = 1'b0;
                    if (cnt_q == BITS_W'(1))
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (vld_p1_q && last_p1_q)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Stage 2: fold the registered plane sum into the accumulator
        if (vld_p1_q) begin
            acc_p2_d = horner(acc_p2_q, sum_p1_q, first_p1_q, signed_q);
            if (last_p1_q) begin
                out_valid_d = 1'b1;
                out_data_d  = acc_p2_d;
            end
        end
    end

    // Stage 1 data: plane sum captured only on accept
    always_ff @(posedge clk) begin
        sum_p1_q <= sum_p1_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            signed_q    <= 1'b0;
            first_q     <= 1'b0;
            vld_p1_q    <= 1'b0;
            first_p1_q  <= 1'b0;
            last_p1_q   <= 1'b0;
            acc_p2_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            signed_q    <= signed_d;
            first_q     <= first_d;
            vld_p1_q    <= vld_p1_d;
            first_p1_q  <= first_p1_d;
            last_p1_q   <= last_p1_d;
            acc_p2_q    <= acc_p2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = (state_q == ST_RUN);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_cim_adder_tree_acc.sv
// Directed bench for cim_adder_tree_acc with a result scoreboard and latency tracking.
module tb_cim_adder_tree_acc;

    localparam int NUM_IN   = 32;
    localparam int IN_W     = 4;
    localparam int MAX_BITS = 8;
    localparam int BITS_W   = 4;
    localparam int SUM_W    = IN_W + $clog2(NUM_IN) + 1;
    localparam int OUT_W    = SUM_W + MAX_BITS + 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic [BITS_W-1:0]      cfg_bits;
    logic                   cfg_signed;
    logic                   in_valid;
    logic [NUM_IN*IN_W-1:0] in_data;
    logic                   in_ready;
    logic                   busy;
    logic                   out_valid;
    logic [OUT_W-1:0]       out_data;
    logic signed [OUT_W-1:0] out_s;

    assign out_s = out_data;

    cim_adder_tree_acc #(
        .NUM_IN(NUM_IN), .IN_W(IN_W), .MAX_BITS(MAX_BITS), .BITS_W(BITS_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_bits(cfg_bits),
        .cfg_signed(cfg_signed), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     vectors = 0;
    int     errs = 0;
    longint exp_q[$];
    int     cyc_q[$];
    int     ps[$];
    int     gp[$];
    longint last_exp;
    int     last_exp_cyc;
    int     start_cyc;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [NUM_IN*IN_W-1:0] make_plane(input int sum);
        logic [NUM_IN*IN_W-1:0] d;
        int rem, off, k, v;
        d = '0;
        rem = sum;
        off = int'($urandom_range(0, NUM_IN - 1));
        for (int i = 0; i < NUM_IN; i++) begin
            k = (off + i) % NUM_IN;
            v = (rem > 15) ? 15 : rem;
            d[k*IN_W +: IN_W] = IN_W'(v);
            rem -= v;
        end
        return d;
    endfunction

    function automatic logic [NUM_IN*IN_W-1:0] rand_data();
        logic [NUM_IN*IN_W-1:0] d;
        for (int k = 0; k < NUM_IN; k++) d[k*IN_W +: IN_W] = IN_W'($urandom);
        return d;
    endfunction

    // Reference: weighted sum of plane sums, MSB plane weight -2^(n-1) when signed.
    function automatic longint model(input int n, input bit sgn);
        longint r = 0;
        longint w;
        for (int i = 0; i < n; i++) begin
            w = longint'(1) << (n - 1 - i);
            if (i == 0 && sgn) r -= longint'(ps[i]) * w;
            else               r += longint'(ps[i]) * w;
        end
        return r;
    endfunction

    // Scoreboard consumer: every out_valid must match the oldest expected result and cycle.
    always @(negedge clk) begin
        longint e;
        int ec;
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                e  = exp_q.pop_front();
                ec = cyc_q.pop_front();
                check("out_data", out_s, e);
                check("latency_cycle", cyc, ec);
            end
        end
    end

    task automatic run_op(input int bits, input bit sgn, input bit poke, input int stop_after);
        int n, nf, c_acc;
        bit ok;
        longint e;
        n  = (bits == 0) ? 1 : ((bits > MAX_BITS) ? MAX_BITS : bits);
        nf = (stop_after > 0) ? stop_after : n;
        c_acc = 0;
        @(posedge clk); #1;
        start = 1'b1; cfg_bits = BITS_W'(bits); cfg_signed = sgn;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; start_cyc = cyc; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin check("start_timeout", 0, 1); start = 1'b0; return; end
        @(posedge clk); #1;
        start = poke; cfg_bits = BITS_W'($urandom); cfg_signed = 1'($urandom);
        for (int i = 0; i < nf; i++) begin
            for (int g = 0; g < gp[i]; g++) begin
                in_valid = 1'b0; in_data = rand_data();
                @(posedge clk); #1;
            end
            in_valid = 1'b1; in_data = make_plane(ps[i]);
            ok = 1'b0;
            for (int t = 0; t < 40; t++) begin
                @(negedge clk);
                if (in_ready) begin ok = 1'b1; c_acc = cyc; break; end
                @(posedge clk); #1;
            end
            if (!ok) begin check("accept_timeout", 0, 1); in_valid = 1'b0; start = 1'b0; return; end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        start = 1'b0;
        if (stop_after == 0) begin
            e = model(n, sgn);
            exp_q.push_back(e);
            cyc_q.push_back(c_acc + 2);
            last_exp = e;
            last_exp_cyc = c_acc + 2;
            @(negedge clk);
            check("in_ready_after_last", in_ready, 0);
        end
    endtask

    initial begin
        int prev_cyc;
        rst_n = 1'b0; start = 1'b0; cfg_bits = '0; cfg_signed = 1'b0;
        in_valid = 1'b0; in_data = '0;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_s, 0);
        @(negedge clk); rst_n = 1'b1;

        // Unsigned, four full planes
        ps = '{480, 480, 480, 480}; gp = '{0, 0, 0, 0};
        run_op(4, 1'b0, 1'b0, 0);
        // Signed, four full planes, started on the previous out_valid cycle
        prev_cyc = last_exp_cyc;
        run_op(4, 1'b1, 1'b0, 0);
        check("b2b_start_cycle", start_cyc, prev_cyc);
        // Signed, eight planes, single 1 in the MSB plane
        ps = '{1, 0, 0, 0, 0, 0, 0, 0}; gp = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_op(8, 1'b1, 1'b0, 0);
        // Bubbles between planes
        ps = '{5, 0, 7}; gp = '{0, 3, 1};
        run_op(3, 1'b0, 1'b0, 0);
        // cfg_bits = 0 acts as one plane
        ps = '{9}; gp = '{0};
        run_op(0, 1'b0, 1'b0, 0);
        // cfg_bits = 15 clamps to eight planes
        ps.delete(); gp.delete();
        for (int i = 0; i < 8; i++) begin
            ps.push_back(int'($urandom_range(0, 480)));
            gp.push_back(int'($urandom_range(0, 2)));
        end
        run_op(15, 1'($urandom), 1'b0, 0);
        // start held high throughout RUN must not restart the operation
        ps = '{100, 200, 300, 400}; gp = '{0, 1, 0, 0};
        run_op(4, 1'b0, 1'b1, 0);

        // in_valid while idle is ignored
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = rand_data();
            @(negedge clk);
            check("idle_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        ps = '{7, 300, 0, 45}; gp = '{0, 0, 2, 0};
        run_op(4, 1'b1, 1'b0, 0);

        // Abort after two of four planes
        ps = '{480, 480, 480, 480}; gp = '{0, 0, 0, 0};
        run_op(4, 1'b0, 1'b0, 2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_out_data", out_s, 0);
        check("abort_in_ready", in_ready, 0);
        @(negedge clk); rst_n = 1'b1;
        ps = '{15, 1, 2, 3}; gp = '{0, 0, 0, 0};
        run_op(4, 1'b0, 1'b0, 0);

        for (int t = 0; t < 20; t++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("out_data_hold", out_s, last_exp);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
